weight_tile_loader: RTL and testbench
=====================================

Name: weight_tile_loader

Overview:
- Upstream sequencer for the BISR weight-allocation stage.
- Takes one tile command (a base row address into the weight buffer SRAM) and issues weight_start to the allocation stage.
- Streams exactly SYSTOLIC_SIZE weight rows from the SRAM as a weight_valid burst.
- Waits for the allocation stage's recovery_done, then reports the recovery outcome (or a timeout) to the controller as a one-cycle result pulse.

Parameters:
- SYSTOLIC_SIZE, 8, rows per tile / PE rows.
- WEIGHT_WIDTH, 8, bits per weight.
- BUF_ADDR_WIDTH, 10, weight-buffer row address width.
- TIMEOUT_CYCLES, 64, max cycles in WAIT_DONE before flagging timeout.
- CNT_WIDTH, $clog2(SYSTOLIC_SIZE+1), row counter width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- cmd_valid  input  1  tile command request.
- cmd_ready  output  1  loader idle, command accepted on valid&ready.
- cmd_base_addr  input  BUF_ADDR_WIDTH  first buffer row of the tile.
- buf_rd_en  output  1  weight-buffer read strobe.
- buf_rd_addr  output  BUF_ADDR_WIDTH  weight-buffer read row.
- buf_rd_data  input  SYSTOLIC_SIZE*WEIGHT_WIDTH  buffer data, valid the cycle after buf_rd_en.
- weight_start  output  1  one-cycle pulse to the allocation stage.
- weight_valid  output  1  row valid to the allocation stage.
- input_weights  output  SYSTOLIC_SIZE*WEIGHT_WIDTH  row to the allocation stage.
- recovery_done  input  1  from the allocation stage.
- recovery_success  input  1  from the allocation stage.
- busy  output  1  state != IDLE.
- result_valid  output  1  one-cycle result pulse.
- result_success  output  1  recovery_success sampled at completion (0 on timeout).
- result_timeout  output  1  WAIT_DONE expired.

Behaviour:
- Reset (rst=1 at a clk edge, any state, including mid-burst):
  - State goes to IDLE.
  - All outputs 0 except cmd_ready=1.
  - Row and timeout counters cleared; base-address register cleared.
  - No partial burst resumes after reset.
- Output timing:
  - cmd_ready and busy are combinational from state.
  - All other outputs are registered, except input_weights (see READ).
- IDLE:
  - cmd_ready=1.
  - On cmd_valid=1: latch cmd_base_addr and go to START.
- START (1 cycle):
  - weight_start=1.
  - Row counter cleared; go to READ.
- READ (SYSTOLIC_SIZE cycles):
  - buf_rd_en=1 every cycle.
  - buf_rd_addr = base + k for k=0..SYSTOLIC_SIZE-1, modulo 2^BUF_ADDR_WIDTH (wraps from max to 0).
  - After the read with k=SYSTOLIC_SIZE-1, go to DRAIN.
  - weight_valid is buf_rd_en delayed by exactly one cycle.
  - input_weights = buf_rd_data while weight_valid=1, else all-zero. It is a combinational pass-through of the registered SRAM output.
  - The burst is contiguous: SYSTOLIC_SIZE back-to-back weight_valid cycles, no gaps, no back-pressure.
  - Row k of the buffer reaches the allocation stage on the k-th weight_valid cycle.
- DRAIN (1 cycle):
  - Last weight_valid is high this cycle.
  - Go to WAIT_DONE; clear the timeout counter.
- WAIT_DONE:
  - recovery_done is ignored in START/READ/DRAIN. It may still be high from the previous tile until weight_start takes effect.
  - On recovery_done=1: capture recovery_success and go to REPORT.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT_CYCLES-1 with recovery_done still 0: set the timeout flag and go to REPORT.
  - recovery_done=1 on the same cycle the count expires counts as done, not timeout.
- REPORT (1 cycle):
  - result_valid=1.
  - result_success = captured value, or 0 on timeout.
  - result_timeout = 1 only on timeout.
  - Go to IDLE.
  - result_* are 0 in every other cycle.
- Commands while busy: cmd_ready=0, so no command is accepted. A cmd_valid held across REPORT is accepted the first IDLE cycle after it.
- Latency:
  - Command accept at cycle 0 (IDLE): weight_start at cycle 1.
  - buf_rd_en at cycles 2..SYSTOLIC_SIZE+1.
  - weight_valid at cycles 3..SYSTOLIC_SIZE+2.
  - Earliest result_valid is 2 cycles after recovery_done is first seen in WAIT_DONE.

Test Plan:
- Reset then idle, no stimulus -> cmd_ready=1; busy, weight_start, weight_valid, buf_rd_en, result_valid all 0; input_weights=0.
- cmd_base_addr=0x010 with buffer row r holding r replicated per byte; allocation model asserts recovery_done=1, recovery_success=1 two cycles after the last weight_valid -> weight_start at cycle 1; buf_rd_addr 0x010..0x017 at cycles 2..9; weight_valid at cycles 3..10 carrying rows 0x10..0x17; single result_valid with success=1, timeout=0.
- cmd_base_addr=0x3FC (BUF_ADDR_WIDTH=10) -> read addresses 0x3FC, 0x3FD, 0x3FE, 0x3FF, 0x000..0x003.
- recovery_done held high from before the command, recovery_success=0 -> done not sampled before WAIT_DONE; result_success=0 reported after the burst completes.
- recovery_done never asserted -> result_valid with timeout=1, success=0 exactly TIMEOUT_CYCLES cycles after entering WAIT_DONE.
- rst=1 at the 4th buf_rd_en, plus cmd_valid pulses while busy -> next cycle all outputs at reset values and state IDLE; no result_valid; commands during busy never accepted.

Source files
------------

// File: rtl/weight_tile_loader_if.sv
// Handshake and data bundle between the weight tile loader and its neighbours:
// controller command/result, weight-buffer SRAM read port, allocation stage.
interface weight_tile_loader_if #(
    parameter int SYSTOLIC_SIZE  = 8,
    parameter int WEIGHT_WIDTH   = 8,
    parameter int BUF_ADDR_WIDTH = 10
);
    logic                                  cmd_valid;
    logic                                  cmd_ready;
    logic [BUF_ADDR_WIDTH-1:0]             cmd_base_addr;
    logic                                  buf_rd_en;
    logic [BUF_ADDR_WIDTH-1:0]             buf_rd_addr;
    logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] buf_rd_data;
    logic                                  weight_start;
    logic                                  weight_valid;
    logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] input_weights;
    logic                                  recovery_done;
    logic                                  recovery_success;
    logic                                  busy;
    logic                                  result_valid;
    logic                                  result_success;
    logic                                  result_timeout;

    modport master (
        input  cmd_valid, cmd_base_addr, buf_rd_data,
        input  recovery_done, recovery_success,
        output cmd_ready, buf_rd_en, buf_rd_addr,
        output weight_start, weight_valid, input_weights,
        output busy, result_valid, result_success, result_timeout
    );

    modport slave (
        output cmd_valid, cmd_base_addr, buf_rd_data,
        output recovery_done, recovery_success,
        input  cmd_ready, buf_rd_en, buf_rd_addr,
        input  weight_start, weight_valid, input_weights,
        input  busy, result_valid, result_success, result_timeout
    );
endinterface

// File: rtl/weight_tile_loader.sv
// Tile sequencer: accepts a base row, streams SYSTOLIC_SIZE weight rows to the
// allocation stage, then reports the recovery outcome or a timeout.
module weight_tile_loader #(
    parameter int SYSTOLIC_SIZE  = 8,
    parameter int WEIGHT_WIDTH   = 8,
    parameter int BUF_ADDR_WIDTH = 10,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = $clog2(SYSTOLIC_SIZE+1)
) (
    input logic                 clk,
    input logic                 rst,
    weight_tile_loader_if.master bus
);
    localparam int DW = SYSTOLIC_SIZE*WEIGHT_WIDTH;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE, START, READ, DRAIN, WAIT_DONE, REPORT
    } state_t;

    state_t state, state_nx;

    logic [BUF_ADDR_WIDTH-1:0] base;
    logic [BUF_ADDR_WIDTH-1:0] rd_addr_q;
    logic [CNT_WIDTH-1:0]      row_cnt;
    logic [TW-1:0]             to_cnt;
    logic succ_q, to_q;
    logic start_q, rd_en_q, wv_q;
    logic rv_q, rs_q, rt_q;
    logic rd_fire, to_hit;

    always_comb begin
        state_nx = state;
        rd_fire  = 1'b0;
        to_hit   = 1'b0;
        unique case (state)
            IDLE:  if (bus.cmd_valid) state_nx = START;
            START: begin
                state_nx = READ;
                rd_fire  = 1'b1;
            end
            READ: begin
                if (row_cnt == CNT_WIDTH'(SYSTOLIC_SIZE)) state_nx = DRAIN;
                else rd_fire = 1'b1;
            end
            DRAIN: state_nx = WAIT_DONE;
            WAIT_DONE: begin
                // done on the expiry cycle still wins over timeout
                if (bus.recovery_done) begin
                    state_nx = REPORT;
                end else if (to_cnt == TW'(TIMEOUT_CYCLES-2)) begin
                    to_hit   = 1'b1;
                    state_nx = REPORT;
                end
            end
            REPORT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            rd_addr_q <= '0;
            row_cnt   <= '0;
            to_cnt    <= '0;
            succ_q    <= 1'b0;
            to_q      <= 1'b0;
            start_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            wv_q      <= 1'b0;
            rv_q      <= 1'b0;
            rs_q      <= 1'b0;
            rt_q      <= 1'b0;
        end else begin
            state   <= state_nx;
            start_q <= (state_nx == START);
            rd_en_q <= rd_fire;
            wv_q    <= rd_en_q;
            rd_addr_q <= rd_fire ?
                base + BUF_ADDR_WIDTH'(row_cnt) : '0;

            if (state == IDLE && bus.cmd_valid)
                base <= bus.cmd_base_addr;

            if (state == IDLE) row_cnt <= '0;
            else if (rd_fire)  row_cnt <= row_cnt + CNT_WIDTH'(1);

            if (state == DRAIN) to_cnt <= '0;
            else if (state == WAIT_DONE && !bus.recovery_done)
                to_cnt <= to_cnt + TW'(1);

            if (state == WAIT_DONE) begin
                if (bus.recovery_done) begin
                    succ_q <= bus.recovery_success;
                    to_q   <= 1'b0;
                end else if (to_hit) begin
                    succ_q <= 1'b0;
                    to_q   <= 1'b1;
                end
            end

            rv_q <= (state == REPORT);
            rs_q <= (state == REPORT) && succ_q;
            rt_q <= (state == REPORT) && to_q;
        end
    end

    assign bus.cmd_ready      = (state == IDLE);
    assign bus.busy           = (state != IDLE);
    assign bus.weight_start   = start_q;
    assign bus.buf_rd_en      = rd_en_q;
    assign bus.buf_rd_addr    = rd_addr_q;
    assign bus.weight_valid   = wv_q;
    assign bus.input_weights  = wv_q ? bus.buf_rd_data : {DW{1'b0}};
    assign bus.result_valid   = rv_q;
    assign bus.result_success = rs_q;
    assign bus.result_timeout = rt_q;
endmodule

// File: tb/tb_weight_tile_loader.sv
// Directed bench for weight_tile_loader: cycle-accurate tile bursts,
// address wrap, stale done, timeout and mid-burst reset.
module tb_weight_tile_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    weight_tile_loader_if #(.SYSTOLIC_SIZE(8), .WEIGHT_WIDTH(8),
                            .BUF_ADDR_WIDTH(10)) bus ();

    weight_tile_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // weight buffer: row r holds low byte of r in every lane, 1-cycle latency
    always @(posedge clk) begin
        if (bus.buf_rd_en) bus.buf_rd_data <= {8{bus.buf_rd_addr[7:0]}};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // cycle 0 = command accept; done driven for done_from..done_to
    task automatic run_tile(input logic [9:0] b, input int done_from,
                            input int done_to, input logic succ,
                            input int res_cyc, input logic res_succ,
                            input logic res_to, input int last);
        logic [9:0] a;
        logic       en, wv;
        for (int c = 0; c <= last; c++) begin
            bus.cmd_valid        = (c == 0);
            bus.cmd_base_addr    = b;
            bus.recovery_done    = (c >= done_from && c <= done_to);
            bus.recovery_success = bus.recovery_done ? succ : 1'b0;
            #0;
            en = (c >= 2 && c <= 9);
            wv = (c >= 3 && c <= 10);
            chk($sformatf("cmd_ready@%0d", c), 64'(bus.cmd_ready),
                64'(c == 0 || c > res_cyc - 1));
            chk($sformatf("busy@%0d", c), 64'(bus.busy),
                64'(c >= 1 && c <= res_cyc - 1));
            chk($sformatf("wstart@%0d", c), 64'(bus.weight_start),
                64'(c == 1));
            chk($sformatf("rd_en@%0d", c), 64'(bus.buf_rd_en), 64'(en));
            a = b + 10'(c - 2);
            if (en) chk($sformatf("rd_addr@%0d", c),
                        64'(bus.buf_rd_addr), 64'(a));
            chk($sformatf("wvalid@%0d", c), 64'(bus.weight_valid), 64'(wv));
            a = b + 10'(c - 3);
            chk($sformatf("weights@%0d", c), bus.input_weights,
                wv ? {8{a[7:0]}} : 64'h0);
            chk($sformatf("rvalid@%0d", c), 64'(bus.result_valid),
                64'(c == res_cyc));
            chk($sformatf("rsucc@%0d", c), 64'(bus.result_success),
                64'(c == res_cyc && res_succ));
            chk($sformatf("rtimeout@%0d", c), 64'(bus.result_timeout),
                64'(c == res_cyc && res_to));
            tick();
        end
        bus.recovery_done    = 1'b0;
        bus.recovery_success = 1'b0;
    endtask

    initial begin
        bus.cmd_valid        = 1'b0;
        bus.cmd_base_addr    = '0;
        bus.recovery_done    = 1'b0;
        bus.recovery_success = 1'b0;
        bus.buf_rd_data      = '0;
        tick(); tick(); tick();
        rst = 1'b0;
        tick(); tick();

        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_wstart", 64'(bus.weight_start), 64'd0);
        chk("rst_wvalid", 64'(bus.weight_valid), 64'd0);
        chk("rst_rd_en", 64'(bus.buf_rd_en), 64'd0);
        chk("rst_rvalid", 64'(bus.result_valid), 64'd0);
        chk("rst_weights", bus.input_weights, 64'h0);

        // nominal tile: done+success at cycle 12, result at 14
        run_tile(10'h010, 12, 12, 1'b1, 14, 1'b1, 1'b0, 16);
        // address wrap 0x3FC..0x003, failed recovery
        run_tile(10'h3FC, 12, 12, 1'b0, 14, 1'b0, 1'b0, 15);
        // stale done held from the start, success=0: seen at 11, result 13
        bus.recovery_done = 1'b1;
        tick(); tick();
        chk("stale_no_start", 64'(bus.busy), 64'd0);
        run_tile(10'h040, 0, 13, 1'b0, 13, 1'b0, 1'b0, 14);
        // success on the stale-free path with done exactly one WAIT cycle in
        run_tile(10'h200, 11, 11, 1'b1, 13, 1'b1, 1'b0, 14);
        // no done: WAIT entered at 11, timeout result 64 cycles later
        run_tile(10'h080, -1, -1, 1'b0, 75, 1'b0, 1'b1, 77);

        // reset at the 4th buf_rd_en (cycle 5), cmd pulses while busy
        for (int c = 0; c <= 5; c++) begin
            bus.cmd_valid     = (c == 0 || c == 2 || c == 4);
            bus.cmd_base_addr = (c == 0) ? 10'h100 : 10'h155;
            rst = (c == 5);
            #0;
            if (c >= 2) chk($sformatf("busy_nocmd_ws@%0d", c),
                            64'(bus.weight_start), 64'd0);
            if (c >= 1) chk($sformatf("busy_ready@%0d", c),
                            64'(bus.cmd_ready), 64'd0);
            if (c >= 2) chk($sformatf("busy_addr@%0d", c),
                            64'(bus.buf_rd_addr), 64'(10'h100 + 10'(c - 2)));
            tick();
        end
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        for (int c = 6; c <= 20; c++) begin
            chk($sformatf("post_rst_ready@%0d", c), 64'(bus.cmd_ready), 64'd1);
            chk($sformatf("post_rst_busy@%0d", c), 64'(bus.busy), 64'd0);
            chk($sformatf("post_rst_rd_en@%0d", c), 64'(bus.buf_rd_en), 64'd0);
            chk($sformatf("post_rst_wv@%0d", c), 64'(bus.weight_valid), 64'd0);
            chk($sformatf("post_rst_w@%0d", c), bus.input_weights, 64'h0);
            chk($sformatf("post_rst_rv@%0d", c), 64'(bus.result_valid), 64'd0);
            chk($sformatf("post_rst_ws@%0d", c), 64'(bus.weight_start), 64'd0);
            tick();
        end

        // loader still fully functional after the aborted burst
        run_tile(10'h3FF, 12, 12, 1'b1, 14, 1'b1, 1'b0, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
